rate_enable_gen: RTL and testbench
==================================

Name: rate_enable_gen

Overview:
Upstream enable source for the 8-bit synchronous counter. It divides the board clock into one-cycle enable pulses at a selectable rate, or issues single pulses from a pushbutton while paused. Its enable_out drives the counter's enable input, and both blocks share the same clock. The block has a run/pause state machine, a loadable down-counter, and a synchronised, edge-detected step input.

Parameters:
CLK_HZ, 50000000, clock frequency in Hz; sets the reload values.
CNT_W, 28, down-counter width; must hold 4*CLK_HZ-1.

Ports:
clock  input  1  system clock; all logic is rising-edge.
clear_b  input  1  asynchronous active-low reset, applied to every flop.
rate_sel  input  2  rate select: 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz.
run  input  1  level input: 1 selects RUN, 0 selects PAUSE. Already synchronous to clock.
step_n  input  1  raw active-low pushbutton, asynchronous to clock.
enable_out  output  1  one-cycle enable pulse to the counter.
running  output  1  1 while the FSM is in RUN.
beat  output  1  toggles on every enable_out pulse (LED heartbeat).

Behaviour:
- Reset (clear_b=0, asynchronous): state=PAUSE, cnt=0, enable_out=0, running=0, beat=0, sync flops=1, rate_q=00.
- Reload value R(sel):
  - 00 -> 0
  - 01 -> CLK_HZ-1
  - 10 -> 2*CLK_HZ-1
  - 11 -> 4*CLK_HZ-1
- enable_out is registered, so it has one cycle of latency from the decision. It is never high for two consecutive cycles except when sel=00 in RUN.
- FSM states: PAUSE, RUN.
  - PAUSE -> RUN when run=1. On entry, cnt loads R(rate_sel).
  - RUN -> PAUSE when run=0. cnt freezes; no pulse is emitted on the exit cycle.
- RUN behaviour:
  - Each cycle, if cnt==0: assert enable_out next cycle and reload cnt=R(rate_sel). Otherwise cnt decrements.
  - With sel=00, cnt is always 0, so enable_out is high every cycle from the second RUN cycle onward.
- Rate change: rate_q registers rate_sel every cycle.
  - If rate_sel!=rate_q in RUN, cnt reloads R(rate_sel) and no pulse is emitted, unless cnt==0 that same cycle.
  - If cnt==0 on the same cycle, the pulse is emitted and the reload uses the new value.
- Step input: step_n passes through a 2-flop synchroniser, then falling-edge detection produces a one-cycle step_pulse.
  - In PAUSE, step_pulse produces enable_out=1 on the next cycle.
  - In RUN, step_pulse is ignored.
  - A held button produces exactly one pulse.
- beat toggles in the same cycle that enable_out is asserted.
- Reset mid-period clears immediately. After release, the block waits in PAUSE until run=1.
- Arithmetic: cnt is unsigned, CNT_W bits. It never wraps below 0, because the reload happens on 0.

Optional Feature:
- Macro RATE_GEN_FAST_SIM_EN.
- When defined, the reload values become 3, 7 and 15 for sel 01, 10 and 11 (pulse periods of 4, 8 and 16 cycles). sel=00 is unchanged.
- When undefined, the CLK_HZ-based values apply.
- Ports and FSM are identical in both builds.

Decomposition:
- Shared package rate_gen_pkg holds:
  - the state encoding (PAUSE=1'b0, RUN=1'b1);
  - rate_sel codes (RATE_FULL=2'b00, RATE_1HZ=2'b01, RATE_HALF=2'b10, RATE_QTR=2'b11);
  - a reload function of (sel, CLK_HZ) that contains the RATE_GEN_FAST_SIM_EN switch.
- One sub-module, step_sync_edge, implements the 2-flop synchroniser plus falling-edge detector.
  - Ports: clock, clear_b, din_n, pulse.
  - The same sub-module is reused for other pushbuttons.

Test Plan (all with RATE_GEN_FAST_SIM_EN defined):
1. Reset, then run=1, sel=01 for 40 cycles -> enable_out high exactly once every 4 cycles (10 pulses); beat toggles 10 times; running=1.
2. sel=00, run=1 -> enable_out continuously high from the 2nd RUN cycle. Drop run to 0 -> enable_out low the next cycle and stays low; running=0.
3. PAUSE, step_n held low for 20 cycles then released -> exactly one enable_out pulse, 3 cycles after the falling edge (2 sync flops + 1 output register). Step pressed during RUN (sel=11) -> no extra pulse; 16-cycle spacing unchanged.
4. RUN, sel=01, switch to sel=11 mid-period (cnt=2) -> no pulse at the old boundary; next pulse 16 cycles after the change. Change coinciding with cnt==0 -> pulse emitted, next pulse 16 cycles later.
5. clear_b pulsed low mid-period, asynchronously between clock edges -> enable_out, running and beat go to 0 immediately. After release with run=1, the first pulse arrives a full period after RUN entry.
6. Counter chain: enable_out drives the counter enable, sel=00, 300 cycles -> counter value wraps 255 -> 0 and reads 300 mod 256 = 44 (±1 for the entry cycle).

Source files
------------

// File: rtl/rate_gen_pkg.sv
// Shared definitions for the rate enable generator: FSM encoding, rate-select
// codes and the reload-value function. Defining RATE_GEN_FAST_SIM_EN swaps the
// CLK_HZ-based reload values for short 4/8/16-cycle periods.
package rate_gen_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [1:0] RATE_FULL = 2'b00;
    localparam logic [1:0] RATE_1HZ  = 2'b01;
    localparam logic [1:0] RATE_HALF = 2'b10;
    localparam logic [1:0] RATE_QTR  = 2'b11;

    // Down-counter start value; the pulse period is this value plus one.
    function automatic logic [31:0] reload_val(input logic [1:0] sel,
                                               input int unsigned clk_hz);
        logic [31:0] r;
`ifdef RATE_GEN_FAST_SIM_EN
        // The clock rate plays no part in the short-period build.
        logic unused_hz;
        unused_hz = ^clk_hz;
        case (sel)
            RATE_1HZ:  r = 32'd3;
            RATE_HALF: r = 32'd7;
            RATE_QTR:  r = 32'd15;
            default:   r = 32'd0;
        endcase
`else
        case (sel)
            RATE_1HZ:  r = clk_hz - 32'd1;
            RATE_HALF: r = (clk_hz * 32'd2) - 32'd1;
            RATE_QTR:  r = (clk_hz * 32'd4) - 32'd1;
            default:   r = 32'd0;
        endcase
`endif
        return r;
    endfunction

endpackage

// File: rtl/step_sync_edge.sv
// Two-flop synchroniser for an asynchronous active-low pushbutton followed by
// a falling-edge detector. A press of any length yields a single-cycle pulse.
module step_sync_edge (
    input  logic clock,
    input  logic clear_b,
    input  logic din_n,
    output logic pulse
);

    logic din_p0;
    logic din_p1;
    logic din_p2;

    // Synchronise the raw button and keep one extra delayed copy for edge detect.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            din_p0 <= 1'b1;
            din_p1 <= 1'b1;
            din_p2 <= 1'b1;
        end else begin
            din_p0 <= din_n;
            din_p1 <= din_p0;
            din_p2 <= din_p1;
        end
    end

    // High for the one cycle where the synchronised level has just gone low.
    assign pulse = din_p2 & ~din_p1;

endmodule

// File: rtl/rate_enable_gen.sv
// Enable-pulse source for the 8-bit counter: a RUN/PAUSE FSM with a loadable
// down-counter producing one-cycle enables at a selectable rate, plus a
// single-step pushbutton honoured only while paused.
// Build option: RATE_GEN_FAST_SIM_EN selects short reload values (3/7/15).
module rate_enable_gen
    import rate_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned CNT_W  = 28
) (
    input  logic       clock,
    input  logic       clear_b,
    input  logic [1:0] rate_sel,
    input  logic       run,
    input  logic       step_n,
    output logic       enable_out,
    output logic       running,
    output logic       beat
);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [1:0]        rate_q;
    logic              enable_d;
    logic              step_pulse;
    logic [CNT_W-1:0]  reload_new;
    logic              cnt_zero;

    step_sync_edge u_step (
        .clock   (clock),
        .clear_b (clear_b),
        .din_n   (step_n),
        .pulse   (step_pulse)
    );

    assign reload_new = CNT_W'(reload_val(rate_sel, CLK_HZ));
    assign cnt_zero   = (cnt_q == '0);
    assign running    = (state_q == RUN);

    // Next state, next count and the enable decision for the coming cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enable_d = 1'b0;
        case (state_q)
            PAUSE: begin
                enable_d = step_pulse;
                if (run) begin
                    state_d = RUN;
                    cnt_d   = reload_new;
                end
            end
            RUN: begin
                if (!run) begin
                    // Count freezes and the exit cycle never pulses.
                    state_d = PAUSE;
                end else if (cnt_zero) begin
                    // A boundary wins over a rate change; reload takes the new rate.
                    enable_d = 1'b1;
                    cnt_d    = reload_new;
                end else if (rate_sel != rate_q) begin
                    cnt_d = reload_new;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = PAUSE;
        endcase
    end

    // State, counter, rate history and registered outputs.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            state_q    <= PAUSE;
            cnt_q      <= '0;
            rate_q     <= RATE_FULL;
            enable_out <= 1'b0;
            beat       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rate_q     <= rate_sel;
            enable_out <= enable_d;
            beat       <= beat ^ enable_d;
        end
    end

endmodule

// File: tb/tb_rate_enable_gen.sv
// Bench for rate_enable_gen. CLK_HZ=4 gives reload values 3/7/15, i.e. the
// same 4/8/16-cycle periods in both the default and the fast-sim build.
module tb_rate_enable_gen;

    logic       clock    = 1'b0;
    logic       clear_b  = 1'b0;
    logic [1:0] rate_sel = 2'b00;
    logic       run      = 1'b0;
    logic       step_n   = 1'b1;
    wire        enable_out;
    wire        running;
    wire        beat;

    always #5 clock = ~clock;

    rate_enable_gen #(
        .CLK_HZ (4),
        .CNT_W  (28)
    ) dut (
        .clock      (clock),
        .clear_b    (clear_b),
        .rate_sel   (rate_sel),
        .run        (run),
        .step_n     (step_n),
        .enable_out (enable_out),
        .running    (running),
        .beat       (beat)
    );

    // Downstream 8-bit counter enabled by the DUT.
    logic [7:0] chain_cnt;
    logic       chain_wrapped;
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            chain_cnt     <= 8'd0;
            chain_wrapped <= 1'b0;
        end else if (enable_out) begin
            chain_cnt <= chain_cnt + 8'd1;
            if (chain_cnt == 8'hFF) chain_wrapped <= 1'b1;
        end
    end

    typedef struct {
        logic [1:0] sel;
        int         period;
        int         cycles;
        int         pulses;
    } vec_t;

    vec_t vecs [4];

    int errors = 0;
    int checks = 0;
    bit exp_q[$];
    int pulse_cnt;
    int beat_toggles;
    logic prev_beat;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Push the expected enable for the coming edge, then pop and compare it.
    task automatic step_cycle(input bit exp_en);
        bit e;
        exp_q.push_back(exp_en);
        tick();
        e = exp_q.pop_front();
        check("enable_out", int'(enable_out), int'(e));
        pulse_cnt += int'(enable_out);
        if (beat !== prev_beat) beat_toggles++;
        prev_beat = beat;
    endtask

    // Periodic train after RUN entry at edge k=1: first pulse at k=P+1.
    function automatic bit train(input int k, input int p);
        return (k >= p + 1) && (((k - 1) % p) == 0);
    endfunction

    task automatic do_reset();
        clear_b  = 1'b0;
        run      = 1'b0;
        step_n   = 1'b1;
        rate_sel = 2'b00;
        tick();
        check("reset_enable", int'(enable_out), 0);
        check("reset_running", int'(running), 0);
        check("reset_beat", int'(beat), 0);
        clear_b = 1'b1;
        tick();
        check("idle_running", int'(running), 0);
        prev_beat    = 1'b0;
        pulse_cnt    = 0;
        beat_toggles = 0;
    endtask

    initial begin
        vecs[0] = '{sel: 2'b00, period: 1,  cycles: 20, pulses: 19};
        vecs[1] = '{sel: 2'b01, period: 4,  cycles: 41, pulses: 10};
        vecs[2] = '{sel: 2'b10, period: 8,  cycles: 41, pulses: 5};
        vecs[3] = '{sel: 2'b11, period: 16, cycles: 49, pulses: 3};

        // Steady-state rates from the table.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            rate_sel = vecs[i].sel;
            tick();
            run = 1'b1;
            pulse_cnt    = 0;
            beat_toggles = 0;
            for (int k = 1; k <= vecs[i].cycles; k++) begin
                step_cycle(train(k, vecs[i].period));
                if (k == 1) check("running_on_entry", int'(running), 1);
            end
            check("pulse_count", pulse_cnt, vecs[i].pulses);
            check("beat_toggles", beat_toggles, vecs[i].pulses);
        end

        // Dropping run at full rate stops enables on the very next cycle.
        do_reset();
        tick();
        run = 1'b1;
        for (int k = 1; k <= 6; k++) step_cycle(train(k, 1));
        run = 1'b0;
        step_cycle(1'b0);
        check("running_after_drop", int'(running), 0);
        for (int k = 1; k <= 4; k++) step_cycle(1'b0);

        // Held step button in PAUSE: one pulse, 3 edges after the press.
        do_reset();
        step_n = 1'b0;
        pulse_cnt = 0;
        for (int k = 1; k <= 20; k++) step_cycle(k == 3);
        step_n = 1'b1;
        for (int k = 1; k <= 5; k++) step_cycle(1'b0);
        check("step_pulse_count", pulse_cnt, 1);

        // Step press during RUN at sel=11 leaves the 16-cycle train untouched.
        do_reset();
        rate_sel = 2'b11;
        tick();
        run = 1'b1;
        for (int k = 1; k <= 49; k++) begin
            if (k == 10) step_n = 1'b0;
            if (k == 14) step_n = 1'b1;
            step_cycle(train(k, 16));
        end

        // Rate change 01->11 while cnt=2: old boundary skipped, pulse 16 later.
        do_reset();
        rate_sel = 2'b01;
        tick();
        run = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            if (k == 11) rate_sel = 2'b11;
            step_cycle(k == 5 || k == 9 || k == 27 || k == 43);
        end

        // Rate change coinciding with cnt==0: pulse kept, next one 16 later.
        do_reset();
        rate_sel = 2'b01;
        tick();
        run = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            if (k == 9) rate_sel = 2'b11;
            step_cycle(k == 5 || k == 9 || k == 25 || k == 41);
        end

        // Asynchronous reset between edges while enable_out and beat are high.
        do_reset();
        rate_sel = 2'b01;
        tick();
        run = 1'b1;
        for (int k = 1; k <= 5; k++) step_cycle(train(k, 4));
        #2 clear_b = 1'b0;
        #1;
        check("async_enable", int'(enable_out), 0);
        check("async_running", int'(running), 0);
        check("async_beat", int'(beat), 0);
        tick();
        clear_b   = 1'b1;
        prev_beat = 1'b0;
        for (int k = 1; k <= 10; k++) step_cycle(train(k, 4));

        // Counter chain at full rate: 300 enabled cycles -> 300 mod 256.
        do_reset();
        tick();
        run = 1'b1;
        repeat (302) tick();
        check("chain_count", int'(chain_cnt), 44);
        check("chain_wrapped", int'(chain_wrapped), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
